// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: req/gnt + rvalid handshake, pipeline stall, lane-aligned load data.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse misalign.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] ld_aligned,
  output logic [2:0]  ld_func3,
  output logic        ld_valid,
  output logic        bus_err,
  output logic        misalign,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     sd_q, sd_d;
  logic            we_q, we_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     ld_al_q, ld_al_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic            ldok_q, ldok_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  logic            start;
  logic            mis_start;
  logic [3:0]      be;
  logic [31:0]     wdata;

  assign start = mem_valid & (mem_is_load | mem_is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (func3[1:0])
      2'b00:   mis_start = 1'b0;
      2'b01:   mis_start = addr[0];
      default: mis_start = |addr[1:0];
    endcase
  end
`else
  assign mis_start = 1'b0;
`endif

  // Lane placement from the latched request; func3 011/110/111 fall through to word.
  always_comb begin
    be    = 4'b1111;
    wdata = sd_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{sd_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wdata = {2{sd_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    sd_d     = sd_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    ld_al_d  = ld_al_q;
    ld_f3_d  = ld_f3_q;
    ldok_d   = ldok_q;
    err_d    = err_q;
    mis_d    = mis_q;
    stall    = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_be    = '0;
    dm_wdata = '0;
    ld_valid = 1'b0;
    bus_err  = 1'b0;
    misalign = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          f3_d    = func3;
          addr_d  = addr;
          sd_d    = store_data;
          we_d    = ~mem_is_load;
          ldok_d  = 1'b0;
          err_d   = 1'b0;
          mis_d   = mis_start;
          state_d = mis_start ? DONE : REQ;
        end
      end
      REQ: begin
        stall    = 1'b1;
        dm_req   = 1'b1;
        dm_we    = we_q;
        dm_addr  = {addr_q[31:2], 2'b00};
        dm_be    = be;
        dm_wdata = wdata;
        if (dm_gnt) begin
          cnt_d   = '0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // rvalid takes priority over a timeout landing on the same cycle
        if (dm_rvalid) begin
          ld_al_d = dm_rdata >> {addr_q[1:0], 3'b000};
          ld_f3_d = f3_q;
          ldok_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          ld_al_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ld_valid = ldok_q;
        bus_err  = err_q;
        misalign = mis_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ld_al_q <= '0;
      ld_f3_q <= '0;
      ldok_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ld_al_q <= ld_al_d;
      ld_f3_q <= ld_f3_d;
      ldok_q  <= ldok_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign ld_aligned = ld_al_q;
  assign ld_func3   = ld_f3_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized load/store transactions against a behavioural byte-lane model of lsu_ctrl.
module tb_lsu_ctrl;
  localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_is_load, mem_is_store;
  logic [2:0]  func3;
  logic [31:0] addr, store_data;
  logic        stall;
  logic [31:0] ld_aligned;
  logic [2:0]  ld_func3;
  logic        ld_valid, bus_err, misalign;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_al;
  logic [2:0]  exp_f3;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_is_load(mem_is_load),
    .mem_is_store(mem_is_store), .func3(func3), .addr(addr), .store_data(store_data),
    .stall(stall), .ld_aligned(ld_aligned), .ld_func3(ld_func3), .ld_valid(ld_valid),
    .bus_err(bus_err), .misalign(misalign), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int s, lo, off, m;
    s   = acc_size(f3);
    lo  = int'(a % 4);
    off = lo - (lo % s);
    m   = ((1 << s) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int s;
    logic [31:0] w, b;
    s = acc_size(f3);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      b = (sd >> (8 * (i % s))) & 32'hFF;
      w = w | (b << (8 * i));
    end
    return w;
  endfunction

  task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int gd, input int rv,
                        input logic [31:0] rd, input string tag);
    int s;
    bit mis, got;
    s   = acc_size(f3);
    mis = TRAP && ((s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00));
    got = 1'b0;
    mem_valid = 1'b1; mem_is_load = ld; mem_is_store = !ld;
    func3 = f3; addr = a; store_data = sd;
    dm_gnt = 1'($urandom); dm_rvalid = 1'($urandom); dm_rdata = $urandom;
    #1;
    chk1({tag, ".issue_stall"}, stall, 1'b1);
    chk1({tag, ".issue_req"}, dm_req, 1'b0);
    tick;
    addr = $urandom; store_data = $urandom; func3 = 3'($urandom);
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    if (!mis) begin
      for (int k = 0; k <= gd; k++) begin
        dm_gnt = (k == gd);
        #1;
        chk1({tag, ".req"}, dm_req, 1'b1);
        chk1({tag, ".req_stall"}, stall, 1'b1);
        chk1({tag, ".we"}, dm_we, !ld);
        chk32({tag, ".addr"}, dm_addr, a - (a % 4));
        chk32({tag, ".be"}, {28'd0, dm_be}, {28'd0, model_be(f3, a)});
        if (!ld) chk32({tag, ".wdata"}, dm_wdata, model_wdata(f3, sd));
        tick;
      end
      dm_gnt = 1'b0;
      if (ld) begin
        for (int j = 0; j < TO && !got; j++) begin
          dm_rvalid = (j == rv);
          dm_rdata  = (j == rv) ? rd : $urandom;
          #1;
          chk1({tag, ".wait_stall"}, stall, 1'b1);
          chk1({tag, ".wait_req"}, dm_req, 1'b0);
          chk1({tag, ".wait_err"}, bus_err, 1'b0);
          if (j == rv) got = 1'b1;
          tick;
        end
        dm_rvalid = 1'b0;
        if (got) begin
          exp_al = rd >> (8 * (a % 4));
          exp_f3 = f3;
        end else begin
          exp_al = '0;
        end
      end
    end
    dm_rvalid = 1'($urandom); dm_rdata = $urandom; dm_gnt = 1'($urandom);
    #1;
    chk1({tag, ".done_stall"}, stall, 1'b0);
    chk1({tag, ".done_req"}, dm_req, 1'b0);
    chk1({tag, ".ld_valid"}, ld_valid, ld && !mis && got);
    chk1({tag, ".bus_err"}, bus_err, ld && !mis && !got);
    chk1({tag, ".misalign"}, misalign, mis);
    chk32({tag, ".ld_aligned"}, ld_aligned, exp_al);
    if (ld && !mis && got) chk32({tag, ".ld_func3"}, {29'd0, ld_func3}, {29'd0, exp_f3});
    tick;
    mem_valid = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = $urandom;
    #1;
    chk1({tag, ".idle_stall"}, stall, 1'b0);
    chk1({tag, ".idle_req"}, dm_req, 1'b0);
    chk1({tag, ".idle_valid"}, ld_valid, 1'b0);
    chk32({tag, ".idle_hold"}, ld_aligned, exp_al);
    dm_rvalid = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    func3 = '0; addr = '0; store_data = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    exp_al = '0; exp_f3 = '0;
    tick; tick;
    chk1("rst.stall", stall, 1'b0);
    chk1("rst.req", dm_req, 1'b0);
    chk1("rst.we", dm_we, 1'b0);
    chk32("rst.addr", dm_addr, 32'h0);
    chk32("rst.be", {28'd0, dm_be}, 32'h0);
    chk32("rst.wdata", dm_wdata, 32'h0);
    chk32("rst.ld_aligned", ld_aligned, 32'h0);
    chk32("rst.ld_func3", {29'd0, ld_func3}, 32'h0);
    chk1("rst.ld_valid", ld_valid, 1'b0);
    chk1("rst.bus_err", bus_err, 1'b0);
    chk1("rst.misalign", misalign, 1'b0);
    rst = 1'b0;
    tick;

    access(1'b1, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234, "lb_103");
    access(1'b0, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 0, 0, 32'h0, "sh_102");
    access(1'b0, 3'b010, 32'h0000_0440, 32'h1234_5678, 3, 0, 32'h0, "sw_gnt3");
    access(1'b1, 3'b010, 32'h0000_0800, 32'h0, 1, 99, 32'h0, "lw_timeout");
    access(1'b1, 3'b010, 32'h0000_0804, 32'h0, 0, TO - 1, 32'hCAFE_F00D, "lw_rv_at_to");
    access(1'b1, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'hA1B2_C3D4, "lw_101");
    access(1'b1, 3'b101, 32'h0000_0202, 32'h0, 2, 1, 32'h8765_4321, "lhu_202");
    access(1'b1, 3'b111, 32'h0000_0300, 32'h0, 0, 2, 32'h0BAD_BEEF, "f3_111");

    // reset lands while a load is waiting for rvalid
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_is_store = 1'b0;
    func3 = 3'b010; addr = 32'h0000_0200;
    tick;
    dm_gnt = 1'b1;
    tick;
    dm_gnt = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; mem_valid = 1'b0;
    exp_al = '0; exp_f3 = '0;
    #1;
    chk1("rstw.req", dm_req, 1'b0);
    chk1("rstw.stall", stall, 1'b0);
    chk32("rstw.ld_aligned", ld_aligned, 32'h0);
    tick;
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("rstw.late_stall", stall, 1'b0);
    chk1("rstw.late_req", dm_req, 1'b0);
    tick;
    dm_rvalid = 1'b0;
    #1;
    chk1("rstw.no_valid", ld_valid, 1'b0);
    chk1("rstw.no_err", bus_err, 1'b0);
    chk32("rstw.hold", ld_aligned, 32'h0);
    tick;

    for (int n = 0; n < 40; n++) begin
      bit rld;
      logic [2:0] rf3;
      rld = 1'($urandom);
      rf3 = rld ? 3'($urandom) : 3'($urandom_range(2, 0));
      access(rld, rf3, $urandom, $urandom, int'($urandom_range(3, 0)),
             int'($urandom_range(5, 0)), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
